// File: rtl/rf_pkg.sv
// Shared types and default geometry for the multi-port RV32I register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-address rule, optional write forwarding,
// and a data register that holds until the next accepted read.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_accept,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              fwd_s;

    // Select the read result; x0 always reads zero even when it is being written.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        fwd_s   = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_addr);
        if (i_accept) begin
            valid_d = 1'b1;
            if (i_addr == '0) begin
                data_d = '0;
            end else if (fwd_s) begin
                data_d = i_wr_data;
            end else begin
                data_d = i_mem_data;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Port output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_rd_data  = data_q;
    assign o_rd_valid = valid_q;

endmodule

// File: rtl/rv32i_register_file_mp.sv
// Multi-read-port, single-write-port register file with x0 hardwired to zero
// and a one-register-per-cycle clear sweep.
module rv32i_register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int BYPASS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_valid,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_valid,
    input  logic                     i_clear,
    output logic                     o_busy
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              busy_q;
    logic              busy_d;
    logic              wr_valid_q;
    logic              wr_valid_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              idle_accept_s;
    logic              wr_fire_s;
    logic [NUM_RD-1:0] rd_accept_s;

    // Requests are only honoured in IDLE and only when no clear is requested.
    always_comb begin
        idle_accept_s = (state_q == IDLE) && !i_clear;
        wr_fire_s     = idle_accept_s && i_wr_en;
        rd_accept_s   = idle_accept_s ? i_rd_en : '0;
    end

    // Next-state logic for the IDLE/CLEAR sweep controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = CLEAR;
                    cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d     = (state_d == CLEAR);
        wr_valid_d = wr_fire_s;
    end

    // Storage update: the sweep owns the write port while clearing.
    always_comb begin
        regs_d = regs_q;
        if (state_q == CLEAR) begin
            regs_d[cnt_q] = '0;
        end else if (wr_fire_s && (i_wr_addr != '0)) begin
            regs_d[i_wr_addr] = i_wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Controller and storage registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = i_rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_accept   (rd_accept_s[k]),
            .i_addr     (addr_s),
            .i_mem_data (regs_q[addr_s]),
            .i_wr_en    (wr_fire_s),
            .i_wr_addr  (i_wr_addr),
            .i_wr_data  (i_wr_data),
            .o_rd_data  (o_rd_data[k*DATA_W +: DATA_W]),
            .o_rd_valid (o_rd_valid[k])
        );
    end

    assign o_busy     = busy_q;
    assign o_wr_valid = wr_valid_q;

endmodule
